button_conditioner: RTL

- Conditions raw board inputs (push-buttons, optionally slide switches) before they reach the user design and the seven-segment display path.
- Per channel: synchronize to CLOCK_100, debounce, then emit a clean level plus one-cycle press, release and auto-repeat pulses.
- Channels are independent and share only the parameters.

---
 rtl/button_conditioner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchronizer, debouncer and auto-repeat pulse generator
module button_conditioner #(
    parameter int NUM_IN          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic              CLOCK_100,
    input  logic              reset,
    input  logic [NUM_IN-1:0] raw_in,
    output logic [NUM_IN-1:0] level,
    output logic [NUM_IN-1:0] press_pulse,
    output logic [NUM_IN-1:0] release_pulse,
    output logic [NUM_IN-1:0] repeat_pulse
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_chain;
        logic                   sync;
        logic [DW-1:0]          db_cnt;
        logic                   lvl_q;
        logic                   press_q;
        logic                   release_q;
        logic                   accept;
        logic                   accept_press;
        logic                   accept_release;

        rpt_state_t             state_q;
        rpt_state_t             state_d;
        logic [RW-1:0]          rcnt_q;
        logic [RW-1:0]          rcnt_d;
        logic                   rpt_q;
        logic                   rpt_d;

        assign sync           = sync_chain[SYNC_STAGES-1];
        assign accept         = (sync != lvl_q) && (db_cnt == DB_LAST);
        assign accept_press   = accept & sync;
        assign accept_release = accept & ~sync;

        // Any disagreement that does not survive the full window restarts the count.
        always_ff @(posedge CLOCK_100) begin
            if (reset) begin
                sync_chain <= '0;
                db_cnt     <= '0;
                lvl_q      <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
            end else begin
                sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw_in[i]};
                if (sync == lvl_q) begin
                    db_cnt <= '0;
                end else if (accept) begin
                    lvl_q  <= sync;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
                press_q   <= accept_press;
                release_q <= accept_release;
            end
        end

        always_ff @(posedge CLOCK_100) begin
            if (reset) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                rpt_q   <= rpt_d;
            end
        end

        // Release wins over a coincident repeat tick so nothing fires on the release cycle.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_press) begin
                        state_d = DELAY;
                        rcnt_d  = '0;
                        rpt_d   = 1'b1;
                    end
                end
                DELAY: begin
                    if (accept_release) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == DELAY_LAST) begin
                        state_d = REPEAT;
                        rcnt_d  = '0;
                        rpt_d   = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                REPEAT: begin
                    if (accept_release) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == PERIOD_LAST) begin
                        rcnt_d = '0;
                        rpt_d  = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        assign level[i]         = lvl_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = rpt_q;
    end

endmodule
